// File: rtl/mfp_ahb_accel_if.sv
// AHB-lite slave-side bus bundle for the accelerometer peripheral.
// Latency: none, wires only.
// Backpressure: none; the slave is zero-wait-state and has no HREADY output.
interface mfp_ahb_accel_if;
   logic [3:0]  HADDR;    // word address, HADDR[5:2] of the system bus
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic        HSEL;
   logic [31:0] HRDATA;

   modport master (
      output HADDR, HTRANS, HWDATA, HWRITE, HSEL,
      input  HRDATA
   );

   modport slave (
      input  HADDR, HTRANS, HWDATA, HWRITE, HSEL,
      output HRDATA
   );
endinterface

// File: rtl/mfp_ahb_accel.sv
// AHB-lite accelerometer slave: decimated X/Y/Z sample FIFO plus board orientation code.
// Latency: HRDATA registered at the end of the address phase; a push shows in STATUS 1 cycle after acc_valid.
// Backpressure: none on the bus; samples arriving at a full FIFO are dropped and set sticky overflow.
// Optional feature macro MFP_ACCEL_ORIENT_EN builds the orientation datapath and THRESH register.
module mfp_ahb_accel #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DIV_W      = 8
) (
   input  logic           HCLK,
   input  logic           HRESET,
   mfp_ahb_accel_if.slave ahb,
   input  logic           acc_valid,
   input  logic [11:0]    x_acc,
   input  logic [11:0]    y_acc,
   input  logic [11:0]    z_acc,
   output logic [2:0]     new_orientation,
   output logic           fifo_irq
);

   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [3:0] A_STATUS  = 4'd0;
   localparam logic [3:0] A_DATA_XY = 4'd1;
   localparam logic [3:0] A_DATA_Z  = 4'd2;
   localparam logic [3:0] A_CTRL    = 4'd3;
   localparam logic [3:0] A_THRESH  = 4'd4;

   // bus pipeline
   logic                  ap_rd;
   logic                  ap_wr;
   logic                  dp_wr;
   logic [3:0]            dp_addr;
   logic                  wr_ctrl;
   logic                  clr;

   // control register
   logic                  enable;
   logic [DIV_W-1:0]      div;
   logic [CNT_W-1:0]      wmark;

   // decimation
   logic [DIV_W-1:0]      dcnt;
   logic                  accept;

   // sample FIFO
   logic [35:0]           mem [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  ovf_set;
   logic [35:0]           head;

   // read path
   logic [2:0]            orient;
   logic [31:0]           rd_dat;

   // HWDATA bits with no register behind them, and HTRANS[0] (SEQ vs NONSEQ is irrelevant here)
   logic                  unused_bits;
   assign unused_bits = ^{ahb.HWDATA[31:21], ahb.HWDATA[7:2], ahb.HTRANS[0]};

   assign ap_rd   = ahb.HSEL & ahb.HTRANS[1] & ~ahb.HWRITE;
   assign ap_wr   = ahb.HSEL & ahb.HTRANS[1] &  ahb.HWRITE;
   assign wr_ctrl = dp_wr && (dp_addr == A_CTRL);
   assign clr     = wr_ctrl && ahb.HWDATA[1];

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign head    = mem[rd_ptr];

   // A DATA_Z read pops at the address-phase edge, the same edge HRDATA captures the head.
   assign pop     = ap_rd && (ahb.HADDR == A_DATA_Z) && !empty;
   assign accept  = enable && acc_valid && (dcnt == div);
   // A pop on the same edge frees a slot, so a push into a full FIFO still succeeds.
   assign push    = accept && (!full || pop);
   assign ovf_set = accept && full && !pop;

   assign fifo_irq = enable && (count >= wmark);

   // Register the address phase so writes can commit with HWDATA at the end of the data phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_wr   <= 1'b0;
         dp_addr <= '0;
      end else begin
         dp_wr   <= ap_wr;
         dp_addr <= ahb.HADDR;
      end
   end

   // CTRL register; the clear bit is an action, not stored state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         enable <= 1'b0;
         div    <= '0;
         wmark  <= '0;
      end else if (wr_ctrl) begin
         enable <= ahb.HWDATA[0];
         div    <= ahb.HWDATA[8 +: DIV_W];
         wmark  <= ahb.HWDATA[16 +: CNT_W];
      end
   end

   // Decimation counter: counts strobes up to DIV, parked at 0 while disabled or cleared.
   always_ff @(posedge HCLK) begin
      if (HRESET || clr || !enable) begin
         dcnt <= '0;
      end else if (acc_valid) begin
         dcnt <= (dcnt == div) ? '0 : dcnt + 1'b1;
      end
   end

   // FIFO pointers, occupancy and sticky overflow; clear wins over a same-cycle push or pop.
   always_ff @(posedge HCLK) begin
      if (HRESET || clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (ovf_set) begin
            overflow <= 1'b1;
         end
      end
   end

   // Sample storage; contents need no reset since count gates every read.
   always_ff @(posedge HCLK) begin
      if (!HRESET && push && !clr) begin
         mem[wr_ptr] <= {x_acc, y_acc, z_acc};
      end
   end

`ifdef MFP_ACCEL_ORIENT_EN
   logic [10:0] thresh;
   logic [11:0] ax;
   logic [11:0] ay;
   logic [11:0] az;
   logic [11:0] mag;
   logic [2:0]  orient_nxt;

   // Magnitude as 12-bit unsigned so that -2048 maps to 2048 without overflow.
   function automatic logic [11:0] abs12(input logic [11:0] v);
      abs12 = v[11] ? (~v + 12'd1) : v;
   endfunction

   // THRESH register.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         thresh <= 11'h100;
      end else if (dp_wr && (dp_addr == A_THRESH)) begin
         thresh <= ahb.HWDATA[10:0];
      end
   end

   // Dominant-axis classification; ties resolve x, then y, then z.
   always_comb begin
      ax         = abs12(x_acc);
      ay         = abs12(y_acc);
      az         = abs12(z_acc);
      mag        = az;
      orient_nxt = z_acc[11] ? 3'd6 : 3'd5;
      if ((ax >= ay) && (ax >= az)) begin
         mag        = ax;
         orient_nxt = x_acc[11] ? 3'd2 : 3'd1;
      end else if (ay >= az) begin
         mag        = ay;
         orient_nxt = y_acc[11] ? 3'd4 : 3'd3;
      end
      if (mag < {1'b0, thresh}) begin
         orient_nxt = 3'd0;
      end
   end

   // Orientation follows every decimated sample, even one dropped by a full FIFO.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         orient <= 3'd0;
      end else if (accept) begin
         orient <= orient_nxt;
      end
   end
`else
   assign orient = 3'd0;
`endif

   assign new_orientation = orient;

   // Register read mux, decoded straight from the address phase.
   always_comb begin
      rd_dat = '0;
      case (ahb.HADDR)
         A_STATUS: begin
            rd_dat[CNT_W-1:0] = count;
            rd_dat[5]         = empty;
            rd_dat[6]         = full;
            rd_dat[7]         = overflow;
            rd_dat[10:8]      = orient;
         end
         A_DATA_XY: begin
            if (!empty) begin
               rd_dat = {4'b0, head[35:24], 4'b0, head[23:12]};
            end
         end
         A_DATA_Z: begin
            if (!empty) begin
               rd_dat = {20'b0, head[11:0]};
            end
         end
         A_CTRL: begin
            rd_dat[0]            = enable;
            rd_dat[8 +: DIV_W]   = div;
            rd_dat[16 +: CNT_W]  = wmark;
         end
`ifdef MFP_ACCEL_ORIENT_EN
         A_THRESH: begin
            rd_dat[10:0] = thresh;
         end
`endif
         default: begin
            rd_dat = '0;
         end
      endcase
   end

   // HRDATA is captured at the address-phase edge and held through the data phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ahb.HRDATA <= '0;
      end else begin
         ahb.HRDATA <= ap_rd ? rd_dat : 32'd0;
      end
   end

endmodule

// File: tb/tb_mfp_ahb_accel.sv
// Directed bench for mfp_ahb_accel: FIFO ordering scoreboard, decimation, overflow, clear and orientation.
// Latency: reads sample HRDATA in the data phase; sample effects are checked one cycle after the strobe.
// Backpressure: none; full-FIFO drop and simultaneous push/pop are exercised directly.
module tb_mfp_ahb_accel;
`ifdef MFP_ACCEL_ORIENT_EN
   localparam bit ORI = 1'b1;
`else
   localparam bit ORI = 1'b0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        acc_valid;
   logic [11:0] x_acc;
   logic [11:0] y_acc;
   logic [11:0] z_acc;
   logic [2:0]  new_orientation;
   logic        fifo_irq;

   int          checks = 0;
   int          errors = 0;

   // scoreboard and decimation model
   logic [35:0] exp_q[$];
   bit          m_en  = 1'b0;
   int          m_div = 0;
   int          m_dcnt = 0;

   mfp_ahb_accel_if bus ();

   mfp_ahb_accel #(.DEPTH_LOG2(4), .DIV_W(8)) dut (
      .HCLK            (HCLK),
      .HRESET          (HRESET),
      .ahb             (bus),
      .acc_valid       (acc_valid),
      .x_acc           (x_acc),
      .y_acc           (y_acc),
      .z_acc           (z_acc),
      .new_orientation (new_orientation),
      .fifo_irq        (fifo_irq)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] st(input logic [2:0] code, input logic [7:0] low);
      return {21'b0, (ORI ? code : 3'd0), low};
   endfunction

   function automatic logic [31:0] oexp(input logic [2:0] code);
      return {29'b0, (ORI ? code : 3'd0)};
   endfunction

   task automatic bus_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HADDR  = 4'd0;
   endtask

   task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge HCLK);
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a;
      @(negedge HCLK);
      bus_idle();
      bus.HWDATA = d;
      @(negedge HCLK);
   endtask

   task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge HCLK);
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a;
      @(negedge HCLK);
      bus_idle();
      d = bus.HRDATA;
   endtask

   task automatic set_ctrl(input logic [31:0] d);
      ahb_write(4'd3, d);
      m_en  = d[0];
      m_div = int'(d[15:8]);
      if (d[1] || !d[0]) m_dcnt = 0;
      if (d[1]) exp_q.delete();
   endtask

   task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
      @(negedge HCLK);
      acc_valid = 1'b1; x_acc = x; y_acc = y; z_acc = z;
      if (m_en) begin
         if (m_dcnt == m_div) begin
            m_dcnt = 0;
            if (exp_q.size() < 16) exp_q.push_back({x, y, z});
         end else begin
            m_dcnt++;
         end
      end
      @(negedge HCLK);
      acc_valid = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      logic [35:0] e;
      logic [31:0] d;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'd0;
      ahb_read(4'd1, d);
      chk({tag, "_xy"}, d, {4'b0, e[35:24], 4'b0, e[23:12]});
      ahb_read(4'd2, d);
      chk({tag, "_z"}, d, {20'b0, e[11:0]});
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      ahb_read(a, d);
      chk(tag, d, exp);
   endtask

   initial begin
      logic [35:0] e;
      HRESET = 1'b1;
      acc_valid = 1'b0; x_acc = '0; y_acc = '0; z_acc = '0;
      bus_idle();
      bus.HWDATA = '0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0;

      // reset state
      chk("rst_hrdata", bus.HRDATA, 32'd0);
      chk("rst_orient", {29'b0, new_orientation}, 32'd0);
      chk("rst_irq", {31'b0, fifo_irq}, 32'd0);
      read_chk("rst_status", 4'd0, 32'h0000_0020);
      read_chk("rst_thresh", 4'd4, ORI ? 32'h0000_0100 : 32'd0);
      read_chk("rst_ctrl", 4'd3, 32'd0);

      // single sample round trip
      set_ctrl(32'h1);
      chk("irq_wm0", {31'b0, fifo_irq}, 32'd1);
      send(12'h123, 12'hFFE, 12'h005);
      read_chk("one_status", 4'd0, st(3'd1, 8'h01));
      read_chk("one_xy_const", 4'd1, 32'h0123_0FFE);
      pop_check("one");
      read_chk("one_empty", 4'd0, st(3'd1, 8'h20));

      // decimation by 4
      set_ctrl(32'h301);
      read_chk("ctrl_div3", 4'd3, 32'h0000_0301);
      for (int i = 0; i < 8; i++) send(12'(16 + i), 12'h000, 12'h000);
      read_chk("div_status", 4'd0, st(3'd0, 8'h02));
      pop_check("div0");
      pop_check("div1");

      // overflow on 20 samples, partial drain, then clear
      set_ctrl(32'h1);
      for (int i = 0; i < 20; i++) send(12'(i), 12'h200, 12'(i * 3));
      read_chk("ovf_status", 4'd0, st(3'd3, 8'hD0));
      for (int i = 0; i < 8; i++) pop_check($sformatf("ovf%0d", i));
      read_chk("ovf_half", 4'd0, st(3'd3, 8'h88));
      set_ctrl(32'h3);
      read_chk("clr_ctrl", 4'd3, 32'h0000_0001);
      read_chk("clr_status", 4'd0, st(3'd3, 8'h20));
      read_chk("empty_pop", 4'd2, 32'd0);
      read_chk("empty_after", 4'd0, st(3'd3, 8'h20));

      // watermark boundary
      set_ctrl(32'h0005_0001);
      chk("irq_wm5_0", {31'b0, fifo_irq}, 32'd0);
      for (int i = 0; i < 4; i++) send(12'h020, 12'h300, 12'h001);
      chk("irq_wm5_4", {31'b0, fifo_irq}, 32'd0);
      send(12'h020, 12'h300, 12'h001);
      chk("irq_wm5_5", {31'b0, fifo_irq}, 32'd1);
      set_ctrl(32'h3);

      // full FIFO with simultaneous pop and push
      for (int i = 0; i < 16; i++) send(12'(256 + i), 12'h200, 12'(i));
      read_chk("full_status", 4'd0, st(3'd3, 8'h50));
      @(negedge HCLK);
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 4'd2;
      acc_valid = 1'b1; x_acc = 12'h0AA; y_acc = 12'h200; z_acc = 12'h0BB;
      e = exp_q.pop_front();
      exp_q.push_back({12'h0AA, 12'h200, 12'h0BB});
      @(negedge HCLK);
      bus_idle();
      acc_valid = 1'b0;
      chk("simul_z", bus.HRDATA, {20'b0, e[11:0]});
      read_chk("simul_status", 4'd0, st(3'd3, 8'h50));
      for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i));
      read_chk("drain_status", 4'd0, st(3'd3, 8'h20));

      // orientation
      send(12'h800, 12'h7FF, 12'h000);
      chk("ori_xneg", {29'b0, new_orientation}, oexp(3'd2));
      send(12'h050, 12'h050, 12'h050);
      chk("ori_below", {29'b0, new_orientation}, oexp(3'd0));
      send(12'h200, 12'h200, 12'h000);
      chk("ori_tie_x", {29'b0, new_orientation}, oexp(3'd1));
      send(12'h000, 12'h000, 12'hF00);
      chk("ori_zneg_eq", {29'b0, new_orientation}, oexp(3'd6));
      send(12'h000, 12'h000, 12'h0FF);
      chk("ori_z_under", {29'b0, new_orientation}, oexp(3'd0));
      send(12'h000, 12'hE00, 12'h100);
      chk("ori_yneg", {29'b0, new_orientation}, oexp(3'd4));
      ahb_write(4'd4, 32'h0000_07FF);
      read_chk("thresh_rw", 4'd4, ORI ? 32'h0000_07FF : 32'd0);
      send(12'h7FE, 12'h000, 12'h000);
      chk("ori_th_under", {29'b0, new_orientation}, oexp(3'd0));
      send(12'h800, 12'h000, 12'h000);
      chk("ori_th_max", {29'b0, new_orientation}, oexp(3'd2));
      read_chk("ori_status", 4'd0, st(3'd2, 8'h08));
      pop_check("ori0");

      // reset during a write data phase discards the write
      @(negedge HCLK);
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 4'd3;
      @(negedge HCLK);
      bus_idle();
      bus.HWDATA = 32'h0000_0301;
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      exp_q.delete();
      m_en = 1'b0; m_div = 0; m_dcnt = 0;
      read_chk("rst_mid_ctrl", 4'd3, 32'd0);
      read_chk("rst_mid_status", 4'd0, 32'h0000_0020);
      read_chk("rst_mid_thresh", 4'd4, ORI ? 32'h0000_0100 : 32'd0);
      chk("rst_mid_orient", {29'b0, new_orientation}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mfp_ahb_accel.md
# mfp_ahb_accel

AHB-lite slave peripheral that sits on the MIPSfpga AHB bus as an additional decoded slave, downstream of the bus decoder/read-mux. Captures signed 12-bit X/Y/Z accelerometer samples from the accelerometer SPI front-end into a 16-entry FIFO, with programmable decimation. Derives a registered 3-bit board orientation code. Exposes FIFO data, status and control as memory-mapped registers.

## Interface
- Parameters:
- `DEPTH_LOG2`, 4: FIFO depth exponent (16 entries).
- `DIV_W`, 8: decimation counter width.
- Ports:
- `HCLK`  in  1  bus clock; all logic on rising edge.
- `HRESET`  in  1  reset, synchronous, active-high.
- `HADDR`  in  4  word address, HADDR[5:2] from the bus.
- `HTRANS`  in  2  AHB transfer type; HTRANS[1]=1 means active.
- `HWDATA`  in  32  write data, valid in data phase.
- `HWRITE`  in  1  1=write.
- `HSEL`  in  1  slave select from decoder.
- `HRDATA`  out  32  read data, registered.
- `acc_valid`  in  1  one-cycle strobe: x/y/z_acc valid.
- `x_acc`, `y_acc`, `z_acc`  in  12 each  two's-complement samples.
- `new_orientation`  out  3  registered orientation code.
- `fifo_irq`  out  1  level: count >= watermark and enabled.

## Operation
- Register map (HADDR[5:2]):
  - 0 STATUS (RO): [4:0] count, [5] empty, [6] full, [7] overflow (sticky), [10:8] orientation.
  - 1 DATA_XY (RO, no side effect): {4'b0, x, 4'b0, y} of head entry.
  - 2 DATA_Z (RO, pops): {20'b0, z} of head; pops the head.
  - 3 CTRL (RW): [0] enable, [1] clear (write-1, self-clearing, reads 0), [15:8] divider DIV, [20:16] watermark.
  - 4 THRESH (RW): [10:0] minimum magnitude for valid orientation.
  - Other offsets: read 0, writes ignored.
- Decimation: when enable=1, each `acc_valid` increments a counter. Sample accepted when counter==DIV; counter then returns to 0. DIV=0 accepts every strobe. Counter holds 0 while enable=0.
- Push on accepted sample: entry {x,y,z} (36 bits). If full: sample dropped, overflow set.
- Pop on DATA_Z read when not empty. When empty: read returns 0, pointers unchanged, no error flag.
- Simultaneous push and pop: both take effect; count unchanged. If full, the push succeeds because a slot frees the same cycle.
- Clear: flushes pointers/count, clears overflow and decimation counter. Orientation is kept. Clear beats a same-cycle push.
- Orientation, updated on each accepted sample:
  - Take |x|, |y|, |z|; max axis wins. Ties prefer x over y over z.
  - Codes: X+ = 1, X− = 2, Y+ = 3, Y− = 4, Z+ = 5, Z− = 6.
  - Code 0 if max < THRESH.
  - Abs of −2048 is 2048, so use 12-bit unsigned.

## Timing
- AHB address phase is qualified by HSEL & HTRANS[1]; its address and HWRITE are registered.
- Write: the register updates at the edge ending the data phase, using HWDATA.
- Read: HRDATA is registered at the edge ending the address phase, so it is valid throughout the data phase. A DATA_Z pop occurs at that same edge.
- Back-to-back transfers are supported with zero wait states; there is no HREADY output.
- Push: an accepted sample appears in count/STATUS 1 cycle after the `acc_valid` edge. `new_orientation` is valid the same cycle.
- `fifo_irq` is combinational from registered count/watermark/enable, so it has 1 cycle latency after push/pop.
- Reset values:
  - HRDATA=0, new_orientation=0, fifo_irq=0.
  - count=0, overflow=0.
  - CTRL=0 (disabled, DIV=0, watermark=0), THRESH=0x100.
- Reset mid-transfer discards the pending write/pop.
- Pointers wrap modulo 16. Count is DEPTH_LOG2+1 bits.

## Configuration
- `MFP_ACCEL_ORIENT_EN`
  - Defined: the orientation datapath, THRESH register and `new_orientation` are built.
  - Undefined: `new_orientation` is tied 0. STATUS[10:8] and THRESH read 0 and THRESH writes are ignored. FIFO behaviour is unchanged.

## Test plan
- Reset, then read STATUS -> 0x00000020 (empty). THRESH reads 0x100. `new_orientation`=0.
- Write CTRL=0x1, push x=0x123, y=0xFFE, z=0x005. Read DATA_XY -> 0x01230FFE. Read DATA_Z -> 0x00000005. Then STATUS -> empty, count 0.
- CTRL=0x301 (DIV=3), 8 strobes -> count=2.
- 20 accepted strobes with no reads -> count=16, full=1, overflow=1. The first 16 samples read back in order. Write CTRL=0x3 -> STATUS reads empty, overflow cleared.
- With full FIFO, pop and push in the same cycle -> count stays 16, overflow stays 0, the new sample lands at the tail.
- x=0x800, y=0x7FF, z=0, THRESH=0x100 -> orientation 2 (X−).
- x=y=z=0x050 -> orientation 0 (below threshold).
- With `MFP_ACCEL_ORIENT_EN` undefined -> orientation always 0.
